// File: rtl/ntt_pkg.sv
// Shared constants, widths and FSM state encoding for the Kyber NTT sequencer.
package ntt_pkg;

   localparam int N       = 256;
   localparam int HALF    = 128;
   localparam int LAYERS  = 7;
   localparam int Q       = 3329;

   localparam int ADDR_W  = $clog2(N);
   localparam int TW_W    = $clog2(HALF);
   localparam int CNT_W   = $clog2(HALF);
   localparam int LAYER_W = $clog2(LAYERS + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // log2 of the butterfly span for a layer: forward halves len each layer
   // (128 .. 2), inverse doubles it (2 .. 128).
   function automatic logic [LAYER_W-1:0] len_log2(input logic inv_mode,
                                                   input logic [LAYER_W-1:0] layer);
      return inv_mode ? LAYER_W'(layer + 1) : LAYER_W'(LAYERS - int'(layer));
   endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth register pipeline carrying {valid, addr_a, addr_b} from the
// issue side to the write-back side.
module ntt_delay_line #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one stage per cycle; reset flushes every in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every stage is cleared, not just the head, because each stage
         // holds a valid bit; a stale one would emit a phantom write after reset.
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/ntt_sequencer.sv
// Address/control sequencer for a 256-point Kyber NTT (CT) or inverse NTT (GS).
// Issues one butterfly per cycle, drains the butterfly pipeline between layers
// and returns write-back addresses aligned to the read + butterfly latency.
module ntt_sequencer
   import ntt_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              inv,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [TW_W-1:0]   tw_addr,
   output logic              ct,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b
);

   localparam int LAT    = RD_LAT + BF_LAT;
   localparam int DCNT_W = $clog2(LAT + 1);
   localparam int DL_W   = 1 + 2 * ADDR_W;

   state_t               state, state_nx;
   logic [LAYER_W-1:0]   layer, layer_nx;
   logic [CNT_W-1:0]     j, j_nx;
   logic [CNT_W-1:0]     g, g_nx;
   logic [TW_W-1:0]      k, k_nx;
   logic [DCNT_W-1:0]    dcnt, dcnt_nx;
   logic                 inv_q, inv_nx;

   logic                 busy_nx, done_nx, rd_en_nx, ct_nx;
   logic [ADDR_W-1:0]    rd_addr_a_nx, rd_addr_b_nx;
   logic [TW_W-1:0]      tw_addr_nx;

   logic [LAYER_W-1:0]   lg;
   logic [ADDR_W-1:0]    len;
   logic [ADDR_W-1:0]    groups;
   logic [CNT_W-1:0]     len_m1, grp_m1;
   logic [ADDR_W-1:0]    issue_a, issue_b;
   logic                 last_j, last_g, last_layer;

   logic [DL_W-1:0]      wr_word;

   // Per-layer geometry and the address pair for the current (g, j).
   always_comb begin
      lg         = len_log2(inv_q, layer);
      len        = ADDR_W'(1) << lg;
      groups     = ADDR_W'(HALF) >> lg;
      len_m1     = CNT_W'(len - ADDR_W'(1));
      grp_m1     = CNT_W'(groups - ADDR_W'(1));
      last_j     = (j == len_m1);
      last_g     = (g == grp_m1);
      last_layer = (layer == LAYER_W'(LAYERS - 1));
      // Span 2*len per group; j < len so the sum never carries into the group bits.
      issue_a    = ({1'b0, g} << ({1'b0, lg} + 4'd1)) + {1'b0, j};
      issue_b    = issue_a + len;
   end

   // Next-state, counter and registered-output logic.
   always_comb begin
      // NOTE: every variable gets a default up front so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_nx     = state;
      layer_nx     = layer;
      j_nx         = j;
      g_nx         = g;
      k_nx         = k;
      dcnt_nx      = dcnt;
      inv_nx       = inv_q;
      busy_nx      = busy;
      done_nx      = 1'b0;
      rd_en_nx     = 1'b0;
      rd_addr_a_nx = '0;
      rd_addr_b_nx = '0;
      tw_addr_nx   = '0;
      ct_nx        = ct;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               inv_nx   = inv;
               ct_nx    = ~inv;
               busy_nx  = 1'b1;
               layer_nx = '0;
               j_nx     = '0;
               g_nx     = '0;
               dcnt_nx  = '0;
               k_nx     = inv ? TW_W'(HALF - 1) : TW_W'(1);
            end
         end

         RUN: begin
            rd_en_nx     = 1'b1;
            rd_addr_a_nx = issue_a;
            rd_addr_b_nx = issue_b;
            tw_addr_nx   = k;
            if (last_j) begin
               j_nx = '0;
               // One twiddle per group; stop stepping after the very last group.
               if (!(last_g && last_layer)) k_nx = inv_q ? k - TW_W'(1) : k + TW_W'(1);
               if (last_g) begin
                  g_nx     = '0;
                  dcnt_nx  = '0;
                  state_nx = DRAIN;
               end else begin
                  g_nx = g + CNT_W'(1);
               end
            end else begin
               j_nx = j + CNT_W'(1);
            end
         end

         DRAIN: begin
            // Between layers wait LAT cycles so the last write lands before the
            // next read; after the final layer wait one more so done follows
            // the last write-back.
            if (last_layer && dcnt == DCNT_W'(LAT)) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               layer_nx = '0;
               dcnt_nx  = '0;
               k_nx     = '0;
            end else if (!last_layer && dcnt == DCNT_W'(LAT - 1)) begin
               state_nx = RUN;
               layer_nx = layer + LAYER_W'(1);
               dcnt_nx  = '0;
            end else begin
               dcnt_nx = dcnt + DCNT_W'(1);
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // State, counters and all issue-side outputs register here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         layer     <= '0;
         j         <= '0;
         g         <= '0;
         k         <= '0;
         dcnt      <= '0;
         inv_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
         ct        <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state     <= state_nx;
         layer     <= layer_nx;
         j         <= j_nx;
         g         <= g_nx;
         k         <= k_nx;
         dcnt      <= dcnt_nx;
         inv_q     <= inv_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         rd_en     <= rd_en_nx;
         rd_addr_a <= rd_addr_a_nx;
         rd_addr_b <= rd_addr_b_nx;
         tw_addr   <= tw_addr_nx;
         ct        <= ct_nx;
      end
   end

   ntt_delay_line #(
      .DEPTH (LAT),
      .WIDTH (DL_W)
   ) u_wr_delay (
      .clk (clk),
      .rst (rst),
      .d   ({rd_en, rd_addr_a, rd_addr_b}),
      .q   (wr_word)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = wr_word;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Self-checking bench for ntt_sequencer: a behavioural model builds the full
// butterfly schedule from the layer/group/offset rules and the observed
// issue and write-back streams are compared against it.
module tb_ntt_sequencer;

   typedef struct {
      int a;
      int b;
      int k;
      int cyc;
   } issue_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, inv = 1'b0;

   logic       a_busy, a_done, a_rd_en, a_ct, a_wr_en;
   logic [7:0] a_ra, a_rb, a_wa, a_wb;
   logic [6:0] a_tw;
   logic       b_busy, b_done, b_rd_en, b_ct, b_wr_en;
   logic [7:0] b_ra, b_rb, b_wa, b_wb;
   logic [6:0] b_tw;

   logic       sel2 = 1'b0;
   logic       o_busy, o_done, o_rd_en, o_ct, o_wr_en;
   logic [7:0] o_ra, o_rb, o_wa, o_wb;
   logic [6:0] o_tw;

   int n_vec = 0;
   int n_err = 0;
   issue_t got_rd[$];
   issue_t got_wr[$];
   int done_cyc, done_cnt;

   always #5 clk = ~clk;

   ntt_sequencer dut (
      .clk(clk), .rst(rst), .start(start_a), .inv(inv),
      .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
      .rd_addr_a(a_ra), .rd_addr_b(a_rb), .tw_addr(a_tw), .ct(a_ct),
      .wr_en(a_wr_en), .wr_addr_a(a_wa), .wr_addr_b(a_wb)
   );

   ntt_sequencer #(.RD_LAT(2), .BF_LAT(6)) dut2 (
      .clk(clk), .rst(rst), .start(start_b), .inv(inv),
      .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
      .rd_addr_a(b_ra), .rd_addr_b(b_rb), .tw_addr(b_tw), .ct(b_ct),
      .wr_en(b_wr_en), .wr_addr_a(b_wa), .wr_addr_b(b_wb)
   );

   // Observe whichever instance the current test targets.
   always_comb begin
      o_busy  = sel2 ? b_busy  : a_busy;
      o_done  = sel2 ? b_done  : a_done;
      o_rd_en = sel2 ? b_rd_en : a_rd_en;
      o_ct    = sel2 ? b_ct    : a_ct;
      o_wr_en = sel2 ? b_wr_en : a_wr_en;
      o_ra    = sel2 ? b_ra    : a_ra;
      o_rb    = sel2 ? b_rb    : a_rb;
      o_wa    = sel2 ? b_wa    : a_wa;
      o_wb    = sel2 ? b_wb    : a_wb;
      o_tw    = sel2 ? b_tw    : a_tw;
   end

   task automatic drive_start(input bit v);
      if (sel2) start_b = v; else start_a = v;
   endtask

   function automatic issue_t rd_at(input int idx);
      issue_t z = '{a: -1, b: -1, k: -1, cyc: -1};
      if (idx < got_rd.size()) return got_rd[idx];
      return z;
   endfunction

   // Run one full operation on the selected DUT, logging every issue and write.
   // With noise on, start and inv are toggled at random while busy.
   task automatic run_op(input bit inv_i, input bit use2, input bit noise, input string tag);
      int lat  = use2 ? 8 : 5;
      int last = 7 * (128 + lat) + 1;
      int nz   = 0;
      sel2 = use2;
      got_rd.delete();
      got_wr.delete();
      done_cyc = -1;
      done_cnt = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      inv = inv_i;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      for (int c = 0; c <= last + 3; c++) begin
         if (o_rd_en) begin
            got_rd.push_back('{a: int'(o_ra), b: int'(o_rb), k: int'(o_tw), cyc: c});
            n_vec++;
            if (o_ct !== ~inv_i) begin
               n_err++;
               $display("FAIL %s ct at cycle %0d: got %0b want %0b", tag, c, o_ct, ~inv_i);
            end
         end else if (o_ra !== 8'd0 || o_rb !== 8'd0 || o_tw !== 7'd0) begin
            nz++;
         end
         if (o_wr_en) got_wr.push_back('{a: int'(o_wa), b: int'(o_wb), k: 0, cyc: c});
         if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == last - 1 || c == last) begin
            n_vec++;
            if (o_busy !== (c == last - 1)) begin
               n_err++;
               $display("FAIL %s busy at cycle %0d: got %0b want %0b", tag, c, o_busy, c == last - 1);
            end
         end
         if (noise && c < last - 10) begin
            inv = 1'($urandom);
            drive_start($urandom_range(0, 7) == 0);
         end else begin
            drive_start(1'b0);
         end
         @(negedge clk);
      end
      n_vec++;
      if (nz != 0) begin
         n_err++;
         $display("FAIL %s idle addresses: got %0d nonzero cycles want 0", tag, nz);
      end
   endtask

   // Compare the logged streams against a schedule built from the NTT rules.
   task automatic check_run(input bit inv_i, input int lat, input string tag);
      issue_t exp_q[$];
      int p = 128 + lat;
      int k = inv_i ? 127 : 1;
      for (int l = 0; l < 7; l++) begin
         int len = inv_i ? (2 << l) : (128 >> l);
         for (int g = 0; g < 128 / len; g++) begin
            for (int j = 0; j < len; j++)
               exp_q.push_back('{a: 2*len*g + j, b: 2*len*g + j + len, k: k,
                                 cyc: 1 + l*p + g*len + j});
            k = inv_i ? k - 1 : k + 1;
         end
      end
      n_vec++;
      if (got_rd.size() != 896) begin
         n_err++;
         $display("FAIL %s rd_en count: got %0d want 896", tag, got_rd.size());
      end
      n_vec++;
      if (got_wr.size() != 896) begin
         n_err++;
         $display("FAIL %s wr_en count: got %0d want 896", tag, got_wr.size());
      end
      for (int i = 0; i < 896; i++) begin
         if (i < got_rd.size()) begin
            n_vec++;
            if (got_rd[i] != exp_q[i]) begin
               n_err++;
               $display("FAIL %s issue %0d: got a=%0d b=%0d k=%0d cyc=%0d want a=%0d b=%0d k=%0d cyc=%0d",
                        tag, i, got_rd[i].a, got_rd[i].b, got_rd[i].k, got_rd[i].cyc,
                        exp_q[i].a, exp_q[i].b, exp_q[i].k, exp_q[i].cyc);
            end
         end
         if (i < got_wr.size()) begin
            n_vec++;
            if (got_wr[i].a != exp_q[i].a || got_wr[i].b != exp_q[i].b ||
                got_wr[i].cyc != exp_q[i].cyc + lat) begin
               n_err++;
               $display("FAIL %s write %0d: got a=%0d b=%0d cyc=%0d want a=%0d b=%0d cyc=%0d",
                        tag, i, got_wr[i].a, got_wr[i].b, got_wr[i].cyc,
                        exp_q[i].a, exp_q[i].b, exp_q[i].cyc + lat);
            end
         end
      end
      if (got_wr.size() == 896 && got_rd.size() == 896) begin
         for (int l = 0; l < 7; l++) begin
            int hits[256];
            int bad = 0;
            foreach (hits[x]) hits[x] = 0;
            for (int i = l*128; i < l*128 + 128; i++) begin
               hits[got_wr[i].a & 255]++;
               hits[got_wr[i].b & 255]++;
            end
            foreach (hits[x]) if (hits[x] != 1) bad++;
            n_vec++;
            if (bad != 0) begin
               n_err++;
               $display("FAIL %s layer %0d coverage: got %0d indices not written once want 0", tag, l, bad);
            end
            if (l < 6) begin
               n_vec++;
               if (got_wr[l*128 + 127].cyc >= got_rd[(l+1)*128].cyc) begin
                  n_err++;
                  $display("FAIL %s layer %0d ordering: got last write %0d first next read %0d want write earlier",
                           tag, l, got_wr[l*128 + 127].cyc, got_rd[(l+1)*128].cyc);
               end
            end
         end
      end
      n_vec++;
      if (done_cnt != 1 || done_cyc != 7*p + 1) begin
         n_err++;
         $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at %0d", tag, done_cnt, done_cyc, 7*p + 1);
      end
   endtask

   task automatic test_reset;
      sel2 = 1'b0;
      n_vec++;
      if ({a_busy, a_done, a_rd_en, a_wr_en, a_ct, a_ra, a_rb, a_tw, a_wa, a_wb,
           b_busy, b_done, b_rd_en, b_wr_en, b_ct} !== '0) begin
         n_err++;
         $display("FAIL reset outputs: got busy=%0b done=%0b rd_en=%0b wr_en=%0b ct=%0b ra=%0d want all 0",
                  a_busy, a_done, a_rd_en, a_wr_en, a_ct, a_ra);
      end
      // Reset in the middle of layer 0.
      inv = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 0; c < 49; c++) @(negedge clk);
      n_vec++;
      if (a_rd_en !== 1'b1 || a_busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset pre-check at cycle 49: got rd_en=%0b busy=%0b want 1 1", a_rd_en, a_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (a_busy !== 1'b0 || a_rd_en !== 1'b0 || a_ct !== 1'b0 || a_ra !== 8'd0) begin
         n_err++;
         $display("FAIL mid-run reset: got busy=%0b rd_en=%0b ct=%0b ra=%0d want 0 0 0 0",
                  a_busy, a_rd_en, a_ct, a_ra);
      end
      begin
         int wr_seen = 0;
         for (int c = 0; c < 8; c++) begin
            if (a_wr_en !== 1'b0 || a_rd_en !== 1'b0) wr_seen++;
            @(negedge clk);
         end
         n_vec++;
         if (wr_seen != 0) begin
            n_err++;
            $display("FAIL post-reset strobes: got %0d cycles with wr_en/rd_en want 0", wr_seen);
         end
      end
   endtask

   task automatic test_forward;
      issue_t t;
      run_op(1'b0, 1'b0, 1'b1, "fwd");
      check_run(1'b0, 5, "fwd");
      t = rd_at(0);
      n_vec++;
      if (t.a != 0 || t.b != 128 || t.k != 1 || t.cyc != 1) begin
         n_err++;
         $display("FAIL fwd issue1: got %0d,%0d,%0d @%0d want 0,128,1 @1", t.a, t.b, t.k, t.cyc);
      end
      t = rd_at(127);
      n_vec++;
      if (t.a != 127 || t.b != 255 || t.k != 1) begin
         n_err++;
         $display("FAIL fwd issue128: got %0d,%0d,%0d want 127,255,1", t.a, t.b, t.k);
      end
      t = rd_at(128);
      n_vec++;
      if (t.a != 0 || t.b != 64 || t.k != 2 || t.cyc != 134) begin
         n_err++;
         $display("FAIL fwd layer2 first: got %0d,%0d,%0d @%0d want 0,64,2 @134", t.a, t.b, t.k, t.cyc);
      end
      t = rd_at(192);
      n_vec++;
      if (t.a != 128 || t.b != 192 || t.k != 3) begin
         n_err++;
         $display("FAIL fwd layer2 issue65: got %0d,%0d,%0d want 128,192,3", t.a, t.b, t.k);
      end
      t = rd_at(895);
      n_vec++;
      if (t.a != 253 || t.b != 255 || t.k != 127) begin
         n_err++;
         $display("FAIL fwd final: got %0d,%0d,%0d want 253,255,127", t.a, t.b, t.k);
      end
      n_vec++;
      if (done_cyc != 932) begin
         n_err++;
         $display("FAIL fwd done cycle: got %0d want 932", done_cyc);
      end
   endtask

   task automatic test_inverse;
      issue_t t;
      int bad = 0;
      run_op(1'b1, 1'b0, 1'b1, "inv");
      check_run(1'b1, 5, "inv");
      t = rd_at(0);
      n_vec++;
      if (t.a != 0 || t.b != 2 || t.k != 127) begin
         n_err++;
         $display("FAIL inv issue1: got %0d,%0d,%0d want 0,2,127", t.a, t.b, t.k);
      end
      t = rd_at(1);
      n_vec++;
      if (t.a != 1 || t.b != 3 || t.k != 127) begin
         n_err++;
         $display("FAIL inv issue2: got %0d,%0d,%0d want 1,3,127", t.a, t.b, t.k);
      end
      t = rd_at(2);
      n_vec++;
      if (t.a != 4 || t.b != 6 || t.k != 126) begin
         n_err++;
         $display("FAIL inv issue3: got %0d,%0d,%0d want 4,6,126", t.a, t.b, t.k);
      end
      for (int i = 768; i < 896; i++) if (rd_at(i).k != 1) bad++;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL inv last-layer twiddle: got %0d issues with k!=1 want 0", bad);
      end
      t = rd_at(895);
      n_vec++;
      if (t.a != 127 || t.b != 255) begin
         n_err++;
         $display("FAIL inv final: got %0d,%0d want 127,255", t.a, t.b);
      end
   endtask

   task automatic test_random_ops;
      for (int r = 0; r < 2; r++) begin
         bit m = 1'($urandom);
         run_op(m, 1'b0, 1'b1, m ? "rnd_inv" : "rnd_fwd");
         check_run(m, 5, m ? "rnd_inv" : "rnd_fwd");
      end
   endtask

   task automatic test_latency;
      bit m = 1'($urandom);
      run_op(m, 1'b1, 1'b1, "lat8");
      check_run(m, 8, "lat8");
      n_vec++;
      if (done_cyc != 953) begin
         n_err++;
         $display("FAIL lat8 done cycle: got %0d want 953", done_cyc);
      end
      sel2 = 1'b0;
   endtask

   task automatic test_back_to_back;
      int rd_cnt = 0, wr_cnt = 0, dn_cnt = 0;
      sel2 = 1'b0;
      inv = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      for (int c = 0; c <= 934; c++) begin
         if (c <= 932) begin
            if (a_rd_en) rd_cnt++;
            if (a_wr_en) wr_cnt++;
            if (a_done) dn_cnt++;
         end
         if (c == 933) begin
            n_vec++;
            if (a_busy !== 1'b1) begin
               n_err++;
               $display("FAIL b2b second accept: got busy=%0b want 1 at cycle 933", a_busy);
            end
         end
         if (c == 934) begin
            n_vec++;
            if (a_rd_en !== 1'b1 || a_ra !== 8'd0 || a_rb !== 8'd128 || a_tw !== 7'd1) begin
               n_err++;
               $display("FAIL b2b second issue: got rd_en=%0b a=%0d b=%0d tw=%0d want 1 0 128 1",
                        a_rd_en, a_ra, a_rb, a_tw);
            end
         end
         @(negedge clk);
      end
      start_a = 1'b0;
      n_vec++;
      if (rd_cnt != 896 || wr_cnt != 896 || dn_cnt != 1) begin
         n_err++;
         $display("FAIL b2b first op: got rd=%0d wr=%0d done=%0d want 896 896 1", rd_cnt, wr_cnt, dn_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset;
      test_forward;
      test_inverse;
      test_random_ops;
      test_latency;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ntt_sequencer.md
# ntt_sequencer

Address and control sequencer that drives the pipelined modular butterfly (q = 3329, 12-bit) through a complete 256-point Kyber NTT (CT mode) or inverse NTT (GS mode). It is the initiator side of the butterfly interface. It issues one butterfly per cycle as coefficient-RAM read addresses, a twiddle-ROM address and the CT select. It returns matching write-back addresses, aligned to the butterfly result latency. Coefficient storage, the twiddle ROM, the butterfly datapath and the final n⁻¹ scaling are outside this block.

## Interface
- RD_LAT, 1, coefficient RAM read latency in cycles
- BF_LAT, 4, butterfly input-to-E/O latency in cycles
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- inv  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final write-back
- rd_en  out  1  issue strobe, one butterfly per high cycle
- rd_addr_a  out  8  even-side coefficient index j
- rd_addr_b  out  8  odd-side coefficient index j+len
- tw_addr  out  7  twiddle ROM index k
- ct  out  1  butterfly mode, ~inv latched at start
- wr_en  out  1  write-back strobe for E/O
- wr_addr_a  out  8  destination for E
- wr_addr_b  out  8  destination for O

## Operation
- States:
  - IDLE: start=1 latches inv and moves to RUN.
  - RUN: issues 128 butterflies, then moves to DRAIN.
  - DRAIN: waits LAT = RD_LAT+BF_LAT cycles. Then it goes to RUN for the next layer, or to IDLE with done=1 after layer 7.
- Layers: 7 layers.
  - Forward: len = 128, 64, …, 2.
  - Inverse: len = 2, 4, …, 128.
- Counters:
  - group g runs 0..(128/len)−1.
  - offset j runs 0..len−1 within each group.
  - Per issue: rd_addr_a = 2·len·g + j, rd_addr_b = rd_addr_a + len. All values are exact; no wrap occurs.
- Twiddle index:
  - Forward: k starts at 1 and increments once per group across all layers, ending at 127.
  - Inverse: k starts at 127 and decrements once per group, ending at 1.
- The write path is a LAT-deep delay of {rd_en, rd_addr_a, rd_addr_b}. wr_en and wr_addr are exactly the issued values, delayed by LAT cycles.
- DRAIN serializes layers. No read of layer L+1 occurs before the last write of layer L, so no RAW hazard is possible.
- start while busy is ignored. A change on inv while busy has no effect.
- rst in any state:
  - Next cycle is IDLE, with all counters zeroed.
  - Every delay-line valid bit is cleared, so no wr_en is emitted for in-flight issues.

## Timing
- Reset values: busy, done, rd_en, wr_en, ct = 0; all addresses = 0.
- Addresses are don't-care when their strobe is low but are held at 0 for bench determinism.
- Cycle numbering: start is sampled at edge 0.
  - Layer i (0-based) asserts rd_en on cycles 1+i·P … 128+i·P, where P = 128+LAT.
  - wr_en follows LAT cycles later.
- Last wr_en is at cycle 7·P. done and busy=0 occur at cycle 7·P+1.
  - Default LAT = 5, so done is at cycle 932.
- A new start is accepted in the same cycle done is high (state is IDLE).
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package ntt_pkg:
  - N = 256, HALF = 128, LAYERS = 7, Q = 3329.
  - Address and twiddle width constants.
  - State enum {IDLE, RUN, DRAIN}.
- One sub-module, ntt_delay_line, parameterized by DEPTH and WIDTH. It has a synchronous clear on rst and carries {valid, addr_a, addr_b} for the write-back path.
- The counters, twiddle up/down counter and FSM live in ntt_sequencer; no other sub-modules.

## Test plan
- Reset mid-RUN (rst at cycle 50 for 1 cycle): next cycle busy=0 and rd_en=0, and no wr_en appears in the following LAT cycles.
- Forward, defaults:
  - Issue 1: a=0, b=128, tw=1, ct=1.
  - Issue 128: a=127, b=255, tw=1.
  - First layer-2 issue: a=0, b=64, tw=2, at cycle 134.
  - Layer-2 issue 65: a=128, b=192, tw=3.
- Forward completion:
  - Final issue: a=253, b=255, tw=127.
  - 896 rd_en and 896 wr_en total.
  - done at cycle 932, exactly one pulse.
- Inverse:
  - Issues 1–3: (0,2,127), (1,3,127), (4,6,126), with ct=0.
  - All 128 issues of the last layer use tw=1.
  - The last layer's final issue is a=127, b=255.
- Write alignment:
  - Each wr_addr pair equals the rd_addr pair issued 5 cycles earlier.
  - Every index 0..255 is written exactly once per layer.
  - No read of layer L+1 occurs before the last write of layer L.
- Protocol edges:
  - start held high through a full run: exactly one op while busy, and a second op is accepted on the done cycle.
  - RD_LAT=2, BF_LAT=6: done at cycle 7·136+1 = 953.
